// File: rtl/msg_egress_fifo.sv
// Message egress FIFO: stores parser messages with their byte length and replays them over valid/ready.
// Define MSG_EGRESS_FIFO_STATS_EN to build the saturating drop/malformed counters; otherwise they read 0.
module msg_egress_fifo #(
  parameter int DATA_WIDTH = 256,
  parameter int BM_WIDTH   = DATA_WIDTH/8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [BM_WIDTH-1:0]         in_bytemask,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [$clog2(BM_WIDTH):0]   out_len,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        full,
  output logic [CNT_WIDTH-1:0]        drop_count,
  output logic [CNT_WIDTH-1:0]        malformed_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int LEN_W = $clog2(BM_WIDTH) + 1;

  logic [PTR_W-1:0]      wr_q, rd_q, wr_d, rd_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [LEN_W-1:0]      len_mem_q [DEPTH];
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [LEN_W-1:0]      out_len_q, out_len_d;

  logic                  mask_ok;
  logic [LEN_W-1:0]      len_c;
  logic [DATA_WIDTH-1:0] data_c;
  logic                  full_c, pop, push_req, push;

  // A legal mask is 2^n-1: nonzero, and adding one clears every set bit.
  always_comb begin
    mask_ok = (in_bytemask != '0) &&
              ((in_bytemask & (in_bytemask + BM_WIDTH'(1))) == '0);
    len_c  = '0;
    data_c = '0;
    for (int j = 0; j < BM_WIDTH; j++) begin
      len_c = len_c + LEN_W'(in_bytemask[j]);
      data_c[8*j +: 8] = in_bytemask[j] ? in_data[8*j +: 8] : 8'h00;
    end
  end

  assign full_c   = (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]) && (wr_q[IDX_W] != rd_q[IDX_W]);
  assign pop      = out_valid_q && out_ready && !flush;
  assign push_req = in_valid && !flush && mask_ok;
  assign push     = push_req && (!full_c || pop);

  // The head register is loaded from the slot rd_d will point at; a same-cycle write to that slot bypasses memory.
  always_comb begin
    wr_d = wr_q + PTR_W'(push);
    rd_d = rd_q + PTR_W'(pop);
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
    out_valid_d = (wr_d != rd_d);
    out_data_d  = '0;
    out_len_d   = '0;
    if (out_valid_d) begin
      if (push && (rd_d == wr_q)) begin
        out_data_d = data_c;
        out_len_d  = len_c;
      end else begin
        out_data_d = mem_q[rd_d[IDX_W-1:0]];
        out_len_d  = len_mem_q[rd_d[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_len_q   <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[IDX_W-1:0]]     <= data_c;
      len_mem_q[wr_q[IDX_W-1:0]] <= len_c;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_len   = out_len_q;
  assign level     = wr_q - rd_q;
  assign full      = full_c;

`ifdef MSG_EGRESS_FIFO_STATS_EN
  logic [CNT_WIDTH-1:0] drop_q, mal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
      mal_q  <= '0;
    end else begin
      if (in_valid && !flush && !mask_ok && (mal_q != '1))
        mal_q <= mal_q + CNT_WIDTH'(1);
      if (push_req && full_c && !pop && (drop_q != '1))
        drop_q <= drop_q + CNT_WIDTH'(1);
    end
  end

  assign drop_count      = drop_q;
  assign malformed_count = mal_q;
`else
  assign drop_count      = '0;
  assign malformed_count = '0;
`endif

endmodule

// File: tb/tb_msg_egress_fifo.sv
// Scoreboard bench for msg_egress_fifo: a queue-based reference model fed by directed and random stimulus.
module tb_msg_egress_fifo;

  localparam int DW      = 256;
  localparam int BW      = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic [DW-1:0]  in_data;
  logic [BW-1:0]  in_bytemask;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [5:0]     out_len;
  logic [2:0]     level;
  logic           full;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] malformed_count;

  msg_egress_fifo #(
    .DATA_WIDTH(DW),
    .BM_WIDTH(BW),
    .DEPTH(DEPTH),
    .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_bytemask(in_bytemask),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_len(out_len),
    .level(level),
    .full(full),
    .drop_count(drop_count),
    .malformed_count(malformed_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   dropExp = 0;
  int   malExp = 0;
  bit   postClear = 1'b0;

  task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Length is the n for which the mask equals 2^n-1; 0 marks a malformed mask.
  function automatic int maskLen(input logic [BW-1:0] m);
    logic [BW:0] t;
    for (int n = 1; n <= BW; n++) begin
      t = (33'd1 << n) - 33'd1;
      if (m == t[BW-1:0]) return n;
    end
    return 0;
  endfunction

  function automatic logic [DW-1:0] keepBytes(input logic [DW-1:0] d, input int n);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[8*j +: 8] = d[8*j +: 8];
    return r;
  endfunction

  function automatic int expCnt(input int c);
`ifdef MSG_EGRESS_FIFO_STATS_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic checkOutput();
    checkVal("level", DW'(level), DW'(sb.size()));
    checkVal("full", DW'(full), DW'(sb.size() == DEPTH));
    checkVal("out_valid", DW'(out_valid), DW'(sb.size() > 0));
    checkVal("drop_count", DW'(drop_count), DW'(expCnt(dropExp)));
    checkVal("malformed_count", DW'(malformed_count), DW'(expCnt(malExp)));
    if (postClear) begin
      checkVal("cleared_out_data", out_data, '0);
      checkVal("cleared_out_len", DW'(out_len), '0);
    end
  endtask

  // Drives one cycle of inputs and advances the reference model by the same cycle.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [BW-1:0] m,
                               input logic f, input logic r);
    int  n;
    bit  popM;
    exp_t e;
    @(negedge clk);
    checkOutput();
    postClear   = 1'b0;
    in_valid    = v;
    in_data     = d;
    in_bytemask = m;
    flush       = f;
    out_ready   = r;
    if (f) begin
      sb.delete();
      postClear = 1'b1;
    end else if (v) begin
      n    = maskLen(m);
      popM = (sb.size() > 0) && r;
      if (n == 0) begin
        if (malExp < CNT_MAX) malExp++;
      end else if ((sb.size() == DEPTH) && !popM) begin
        if (dropExp < CNT_MAX) dropExp++;
      end else begin
        e.data = keepBytes(d, n);
        e.len  = n;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    dropExp   = 0;
    malExp    = 0;
    postClear = 1'b1;
    @(negedge clk);
    checkOutput();
    reset_n = 1'b1;
  endtask

  // Monitor: every accepted head is compared against the oldest expected message.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got len %0d expected no output at %0t", out_len, $time);
        end else begin
          e = sb.pop_front();
          checkVal("out_data", out_data, e.data);
          checkVal("out_len", DW'(out_len), DW'(e.len));
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    logic [BW:0]   t;
    logic [BW-1:0] m;
    int            sel;
    bit            readyBias;

    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_bytemask = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    postClear   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput();
    reset_n = 1'b1;

    $display("[TB] single 8-byte message");
    d = randData();
    for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(j + 1);
    applyStimulus(1'b1, d, 32'h0000_00FF, 1'b0, 1'b1);
    idle(3);

    $display("[TB] fill to full, overflow, push+pop while full");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randData(), 32'h0000_FFFF, 1'b0, 1'b0);
    applyStimulus(1'b1, randData(), 32'h0000_FFFF, 1'b0, 1'b1);
    idle(7);

    $display("[TB] push+pop at level 1");
    applyStimulus(1'b1, randData(), 32'h0000_000F, 1'b0, 1'b0);
    applyStimulus(1'b1, randData(), 32'h0000_03FF, 1'b0, 1'b1);
    idle(3);

    $display("[TB] malformed masks and full-width mask");
    applyStimulus(1'b1, randData(), 32'h0000_0000, 1'b0, 1'b1);
    applyStimulus(1'b1, randData(), 32'h0000_00F5, 1'b0, 1'b1);
    applyStimulus(1'b1, randData(), 32'hFFFF_FFFF, 1'b0, 1'b1);
    idle(3);

    $display("[TB] flush with coincident push");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randData(), 32'h0000_00FF, 1'b0, 1'b0);
    applyStimulus(1'b1, randData(), 32'h0000_00FF, 1'b1, 1'b0);
    idle(5);

    $display("[TB] drop counter saturation");
    for (int i = 0; i < DEPTH + 18; i++) applyStimulus(1'b1, randData(), 32'h0000_0001, 1'b0, 1'b0);
    idle(6);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, randData(), 32'h0000_0007, 1'b0, 1'b0);
    applyStimulus(1'b1, randData(), 32'h0000_00FF, 1'b0, 1'b0);
    doReset();
    idle(3);

    $display("[TB] random traffic");
    readyBias = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) readyBias = ~readyBias;
      sel = $urandom_range(0, 9);
      if (sel == 0) m = '0;
      else if (sel == 1) m = $urandom;
      else if (sel == 2) m = '1;
      else begin
        t = (33'd1 << $urandom_range(1, BW)) - 33'd1;
        m = t[BW-1:0];
      end
      applyStimulus($urandom_range(0, 9) < 7, randData(), m, $urandom_range(0, 49) == 0,
                    readyBias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1);
    idle(1);
    checkVal("drain_remaining", DW'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
